// File: rtl/single_divider.sv
// IEEE-754 single-precision divider z = a / b: restoring mantissa divide (1 quotient bit/cycle), round-to-nearest-even.
// Latency from b-transfer edge to output_z_stb: 38 cycles (a_m >= b_m), 39 (a_m < b_m), 2 for special operands.
// Backpressure: one operation in flight; output_z_stb/output_z hold until output_z_ack, inputs are not acked meanwhile.
//
// Ports: clk, rst (async, active high); input_a/_stb/_ack and input_b/_stb/_ack operand handshakes;
//        output_z/_stb/_ack result handshake. Parameter CANON_NAN is returned for every invalid/NaN result.
// Build option: define SINGLE_DIVIDER_DENORM_EN for subnormal inputs/results; otherwise flush-to-zero.
module single_divider #(
    parameter logic [31:0] CANON_NAN = 32'hFFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    typedef enum logic [3:0] {
        GET_A, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B, DIV_0,
        DIV_1, DIV_2, NORM_1, NORM_2, ROUND, PACK, PUT_Z
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d, out_z_q, out_z_d;
    logic               a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;
    logic [23:0]        a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;
    logic signed [9:0]  a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
    logic               a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
    logic               guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;
    logic [26:0]        quot_q, quot_d;
    logic [25:0]        rem_q, rem_d;
    logic [4:0]         count_q, count_d;

    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

    assign input_a_ack  = a_ack_q;
    assign input_b_ack  = b_ack_q;
    assign output_z     = out_z_q;
    assign output_z_stb = z_stb_q;

    // Operand classes, valid while in SPECIAL (exponents already unbiased).
    assign a_nan = (a_e_q == 10'sd128) && (a_m_q != 24'd0);
    assign a_inf = (a_e_q == 10'sd128) && (a_m_q == 24'd0);
    assign b_nan = (b_e_q == 10'sd128) && (b_m_q != 24'd0);
    assign b_inf = (b_e_q == 10'sd128) && (b_m_q == 24'd0);
`ifdef SINGLE_DIVIDER_DENORM_EN
    assign a_zero = (a_e_q == -10'sd127) && (a_m_q == 24'd0);
    assign b_zero = (b_e_q == -10'sd127) && (b_m_q == 24'd0);
`else
    // Flush-to-zero: any zero exponent field counts as signed zero.
    assign a_zero = (a_e_q == -10'sd127);
    assign b_zero = (b_e_q == -10'sd127);
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;       b_d      = b_q;       out_z_d  = out_z_q;
        a_ack_d  = a_ack_q;   b_ack_d  = b_ack_q;   z_stb_d  = z_stb_q;
        a_m_d    = a_m_q;     b_m_d    = b_m_q;     z_m_d    = z_m_q;
        a_e_d    = a_e_q;     b_e_d    = b_e_q;     z_e_d    = z_e_q;
        a_s_d    = a_s_q;     b_s_d    = b_s_q;     z_s_d    = z_s_q;
        guard_d  = guard_q;   round_d  = round_q;   sticky_d = sticky_q;
        quot_d   = quot_q;    rem_d    = rem_q;     count_d  = count_q;

        case (state_q)
            GET_A: begin
                a_ack_d = 1'b1;
                if (a_ack_q && input_a_stb) begin
                    a_d     = input_a;
                    a_ack_d = 1'b0;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                b_ack_d = 1'b1;
                if (b_ack_q && input_b_stb) begin
                    b_d     = input_b;
                    b_ack_d = 1'b0;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                a_m_d   = {1'b0, a_q[22:0]};
                b_m_d   = {1'b0, b_q[22:0]};
                a_e_d   = $signed({2'b00, a_q[30:23]}) - 10'sd127;
                b_e_d   = $signed({2'b00, b_q[30:23]}) - 10'sd127;
                a_s_d   = a_q[31];
                b_s_d   = b_q[31];
                state_d = SPECIAL;
            end
            SPECIAL: begin
                if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
                    out_z_d = CANON_NAN;
                    z_stb_d = 1'b1;
                    state_d = PUT_Z;
                end else if (a_inf || b_zero) begin
                    out_z_d = {a_s_q ^ b_s_q, 8'hFF, 23'd0};
                    z_stb_d = 1'b1;
                    state_d = PUT_Z;
                end else if (a_zero || b_inf) begin
                    out_z_d = {a_s_q ^ b_s_q, 31'd0};
                    z_stb_d = 1'b1;
                    state_d = PUT_Z;
                end else begin
                    // Denormals keep a zero hidden bit and take the minimum exponent.
                    if (a_e_q == -10'sd127) a_e_d = -10'sd126;
                    else                    a_m_d = a_m_q | 24'h800000;
                    if (b_e_q == -10'sd127) b_e_d = -10'sd126;
                    else                    b_m_d = b_m_q | 24'h800000;
                    state_d = NORM_A;
                end
            end
            NORM_A: begin
`ifdef SINGLE_DIVIDER_DENORM_EN
                if (a_m_q[23]) state_d = NORM_B;
                else begin
                    a_m_d = a_m_q << 1;
                    a_e_d = a_e_q - 10'sd1;
                end
`else
                state_d = NORM_B;
`endif
            end
            NORM_B: begin
`ifdef SINGLE_DIVIDER_DENORM_EN
                if (b_m_q[23]) state_d = DIV_0;
                else begin
                    b_m_d = b_m_q << 1;
                    b_e_d = b_e_q - 10'sd1;
                end
`else
                state_d = DIV_0;
`endif
            end
            DIV_0: begin
                z_s_d   = a_s_q ^ b_s_q;
                z_e_d   = a_e_q - b_e_q;
                quot_d  = 27'd0;
                rem_d   = {2'b00, a_m_q};
                count_d = 5'd0;
                state_d = DIV_1;
            end
            DIV_1: begin
                // rem is kept pre-doubled for the next bit, so it ends at 2x the true remainder.
                if (rem_q >= {2'b00, b_m_q}) begin
                    quot_d = {quot_q[25:0], 1'b1};
                    rem_d  = (rem_q - {2'b00, b_m_q}) << 1;
                end else begin
                    quot_d = {quot_q[25:0], 1'b0};
                    rem_d  = rem_q << 1;
                end
                if (count_q == 5'd26) state_d = DIV_2;
                else                  count_d = count_q + 5'd1;
            end
            DIV_2: begin
                z_m_d    = quot_q[26:3];
                guard_d  = quot_q[2];
                round_d  = quot_q[1];
                sticky_d = quot_q[0] | (rem_q != 26'd0);
                state_d  = NORM_1;
            end
            NORM_1: begin
                if (!z_m_q[23]) begin
                    z_m_d   = {z_m_q[22:0], guard_q};
                    guard_d = round_q;
                    round_d = 1'b0;
                    z_e_d   = z_e_q - 10'sd1;
                end else begin
`ifdef SINGLE_DIVIDER_DENORM_EN
                    state_d = NORM_2;
`else
                    // Underflow flushes: zero mantissa at exponent -126 packs as +/-0.
                    if (z_e_q < -10'sd126) begin
                        z_m_d   = 24'd0;
                        z_e_d   = -10'sd126;
                        state_d = PACK;
                    end else begin
                        state_d = NORM_2;
                    end
`endif
                end
            end
            NORM_2: begin
`ifdef SINGLE_DIVIDER_DENORM_EN
                if (z_e_q < -10'sd126) begin
                    z_e_d    = z_e_q + 10'sd1;
                    z_m_d    = z_m_q >> 1;
                    guard_d  = z_m_q[0];
                    round_d  = guard_q;
                    sticky_d = sticky_q | round_q;
                end else begin
                    state_d = ROUND;
                end
`else
                state_d = ROUND;
`endif
            end
            ROUND: begin
                if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
                    z_m_d = z_m_q + 24'd1;
                    // Mantissa wraps to 0; the hidden bit moves into the exponent.
                    if (z_m_q == 24'hFFFFFF) z_e_d = z_e_q + 10'sd1;
                end
                state_d = PACK;
            end
            PACK: begin
                out_z_d = {z_s_q, 8'(z_e_q + 10'sd127), z_m_q[22:0]};
                if ((z_e_q == -10'sd126) && !z_m_q[23]) out_z_d[30:23] = 8'd0;
                if (z_e_q > 10'sd127)                   out_z_d[30:0]  = {8'hFF, 23'd0};
                state_d = PUT_Z;
            end
            PUT_Z: begin
                z_stb_d = 1'b1;
                if (z_stb_q && output_z_ack) begin
                    z_stb_d = 1'b0;
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= GET_A;
            a_q     <= '0;  b_q     <= '0;  out_z_q <= '0;
            a_ack_q <= 1'b0; b_ack_q <= 1'b0; z_stb_q <= 1'b0;
            a_m_q   <= '0;  b_m_q   <= '0;  z_m_q   <= '0;
            a_e_q   <= '0;  b_e_q   <= '0;  z_e_q   <= '0;
            a_s_q   <= 1'b0; b_s_q  <= 1'b0; z_s_q  <= 1'b0;
            guard_q <= 1'b0; round_q <= 1'b0; sticky_q <= 1'b0;
            quot_q  <= '0;  rem_q   <= '0;  count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;     b_q     <= b_d;     out_z_q <= out_z_d;
            a_ack_q <= a_ack_d; b_ack_q <= b_ack_d; z_stb_q <= z_stb_d;
            a_m_q   <= a_m_d;   b_m_q   <= b_m_d;   z_m_q   <= z_m_d;
            a_e_q   <= a_e_d;   b_e_q   <= b_e_d;   z_e_q   <= z_e_d;
            a_s_q   <= a_s_d;   b_s_q   <= b_s_d;   z_s_q   <= z_s_d;
            guard_q <= guard_d; round_q <= round_d; sticky_q <= sticky_d;
            quot_q  <= quot_d;  rem_q   <= rem_d;   count_q <= count_d;
        end
    end

endmodule
